// File: rtl/exception_sequencer.sv
// exception_sequencer: multicycle exception entry (latch EPC/cause, fetch vector byte, one PC write); EXC_DIVZERO_EN enables div_zero as cause 11
module exception_sequencer #(
  parameter logic [31:0] VEC_BASE = 32'd253,
  parameter int          MEM_LAT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_check,
  input  logic        opcode_inv,
  input  logic        overflow,
  input  logic        div_zero,
  input  logic [31:0] pc_cur,
  input  logic [7:0]  mem_data,
  output logic        busy,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic [2:0]  pc_src_sel,
  output logic        pc_write,
  output logic [31:0] handler_pc,
  output logic [31:0] epc,
  output logic [1:0]  cause
);
  typedef enum logic [1:0] {IDLE, READ, JUMP} state_t;
  localparam logic [3:0] LAT = 4'(MEM_LAT);
  state_t     state;
  logic [3:0] cnt;
  logic [1:0] code;
`ifdef EXC_DIVZERO_EN
  assign code = opcode_inv ? 2'b01 : overflow ? 2'b10 : div_zero ? 2'b11 : 2'b00;
`else
  logic unused_div_zero;
  assign unused_div_zero = div_zero;
  assign code = opcode_inv ? 2'b01 : overflow ? 2'b10 : 2'b00;
`endif
  // sequencer FSM; every output is a register updated on the same edge as the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      mem_read   <= 1'b0;
      mem_addr   <= '0;
      pc_src_sel <= '0;
      pc_write   <= 1'b0;
      handler_pc <= '0;
      epc        <= '0;
      cause      <= '0;
    end else begin
      case (state)
        IDLE: if (exc_check && code != 2'b00) begin
          state    <= READ;
          cnt      <= '0;
          busy     <= 1'b1;
          mem_read <= 1'b1;
          mem_addr <= VEC_BASE + {30'b0, code} - 32'd1;
          epc      <= pc_cur - 32'd4;
          cause    <= code;
        end
        READ: if (cnt == LAT) begin
          state      <= JUMP;
          mem_read   <= 1'b0;
          mem_addr   <= '0;
          handler_pc <= {24'b0, mem_data};
          pc_src_sel <= 3'b100;
          pc_write   <= 1'b1;
        end else begin
          cnt <= cnt + 4'd1;
        end
        JUMP: begin
          state      <= IDLE;
          busy       <= 1'b0;
          pc_src_sel <= '0;
          pc_write   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exception_sequencer.sv
// tb_exception_sequencer: directed stimulus, cycle-timeline reference model, literal spot checks
module tb_exception_sequencer;
  localparam int L  = 2;
  localparam logic [31:0] VB = 32'd253;
  logic        clk, reset, exc_check, opcode_inv, overflow, div_zero;
  logic [31:0] pc_cur;
  logic [7:0]  mem_data;
  logic        busy, mem_read, pc_write;
  logic [31:0] mem_addr, handler_pc, epc;
  logic [2:0]  pc_src_sel;
  logic [1:0]  cause;
  int checks = 0, errors = 0, pulses = 0, cyc = 0, start = 0, p0;
  bit go = 0, active = 0;
  logic [31:0] m_epc = 0, m_hpc = 0;
  logic [1:0]  m_cause = 0;

  exception_sequencer #(.VEC_BASE(VB), .MEM_LAT(L)) dut (
    .clk(clk), .reset(reset), .exc_check(exc_check), .opcode_inv(opcode_inv),
    .overflow(overflow), .div_zero(div_zero), .pc_cur(pc_cur), .mem_data(mem_data),
    .busy(busy), .mem_read(mem_read), .mem_addr(mem_addr), .pc_src_sel(pc_src_sel),
    .pc_write(pc_write), .handler_pc(handler_pc), .epc(epc), .cause(cause));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [1:0] cause_of();
`ifdef EXC_DIVZERO_EN
    return opcode_inv ? 2'd1 : overflow ? 2'd2 : div_zero ? 2'd3 : 2'd0;
`else
    return opcode_inv ? 2'd1 : overflow ? 2'd2 : 2'd0;
`endif
  endfunction

  // reference model: an accepted exception at edge `start` gives READ for k=0..L, JUMP at k=L+1, idle from k=L+2
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      active = 0; m_epc = 0; m_hpc = 0; m_cause = 0;
    end else if (active) begin
      if (cyc - start == L + 1) m_hpc = {24'b0, mem_data};
      if (cyc - start == L + 2) active = 0;
    end else if (exc_check && cause_of() != 0) begin
      active = 1; start = cyc; m_epc = pc_cur - 32'd4; m_cause = cause_of();
    end
  end

  // compare every cycle against the model
  always @(negedge clk) if (go) begin
    automatic int k = cyc - start;
    automatic bit rd = active && k <= L;
    automatic bit jp = active && k == L + 1;
    chk("busy", busy, active);
    chk("mem_read", mem_read, rd);
    chk("mem_addr", mem_addr, rd ? VB + m_cause - 1 : 0);
    chk("pc_src_sel", pc_src_sel, jp ? 3'b100 : 3'b000);
    chk("pc_write", pc_write, jp);
    chk("handler_pc", handler_pc, m_hpc);
    chk("epc", epc, m_epc);
    chk("cause", cause, m_cause);
    pulses += pc_write;
  end

  initial begin
    reset = 1; exc_check = 0; opcode_inv = 0; overflow = 0; div_zero = 0;
    pc_cur = 0; mem_data = 0;
    step(2);
    go = 1;
    chk("rst_busy", busy, 0);
    chk("rst_epc", epc, 0);
    chk("rst_handler", handler_pc, 0);
    reset = 0;
    exc_check = 1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("nocause_busy", busy, 0);
      chk("nocause_sel", pc_src_sel, 0);
      chk("nocause_epc", epc, 0);
    end
    pc_cur = 32'h10; overflow = 1; mem_data = 8'h7C;
    step(1);
    exc_check = 0; overflow = 0;
    chk("ovf_addr1", mem_addr, 254);
    step(1);
    chk("ovf_addr2", mem_addr, 254);
    step(1);
    chk("ovf_addr3", mem_addr, 254);
    chk("ovf_read3", mem_read, 1);
    step(1);
    chk("ovf_sel", pc_src_sel, 3'b100);
    chk("ovf_pcw", pc_write, 1);
    chk("ovf_handler", handler_pc, 32'h7C);
    chk("ovf_epc", epc, 32'hC);
    chk("ovf_cause", cause, 2);
    step(1);
    chk("ovf_done", busy, 0);
    chk("ovf_hold", handler_pc, 32'h7C);
    pc_cur = 32'h100; opcode_inv = 1; overflow = 1; div_zero = 1; exc_check = 1; mem_data = 8'h11;
    step(1);
    exc_check = 0; opcode_inv = 0; overflow = 0; div_zero = 0;
    chk("prio_cause", cause, 1);
    chk("prio_addr", mem_addr, 253);
    step(4);
    chk("prio_handler", handler_pc, 32'h11);
    chk("prio_epc", epc, 32'hFC);
    p0 = pulses;
    pc_cur = 32'h40; overflow = 1; exc_check = 1; mem_data = 8'h22;
    step(1);
    overflow = 0; opcode_inv = 1;
    step(1);
    chk("busy_ign_cause", cause, 2);
    exc_check = 0; opcode_inv = 0;
    step(3);
    chk("busy_ign_pulses", pulses - p0, 1);
    chk("busy_ign_handler", handler_pc, 32'h22);
    chk("busy_ign_idle", busy, 0);
    p0 = pulses;
    pc_cur = 32'h80; overflow = 1; exc_check = 1; mem_data = 8'h33;
    step(1);
    exc_check = 0; overflow = 0;
    step(1);
    reset = 1;
    step(1);
    reset = 0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_addr", mem_addr, 0);
    chk("rst_mid_epc", epc, 0);
    chk("rst_mid_cause", cause, 0);
    chk("rst_mid_handler", handler_pc, 0);
    step(4);
    chk("rst_mid_pulses", pulses - p0, 0);
    reset = 1; exc_check = 1; opcode_inv = 1;
    step(1);
    reset = 0; exc_check = 0; opcode_inv = 0;
    chk("rst_prio_busy", busy, 0);
    pc_cur = 32'h0; div_zero = 1; exc_check = 1; mem_data = 8'h44;
    step(1);
    exc_check = 0; div_zero = 0;
`ifdef EXC_DIVZERO_EN
    chk("dz_epc", epc, 32'hFFFFFFFC);
    chk("dz_addr", mem_addr, 255);
    chk("dz_cause", cause, 3);
`else
    chk("dz_busy", busy, 0);
    chk("dz_cause", cause, 0);
`endif
    step(6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
